led_pattern_seq: RTL and testbench

Parametrised LED pattern sequencer. Drives NLEDS outputs from a programmable-period tick, in one of four run-time-selectable modes: rotate left, rotate right, bounce (ping-pong) and binary count. It also supports run/pause and emits a step strobe. It sits directly on the board LED pins or on a PMod LED header. Pattern state and prescaler are fully synchronous to CLK.

---
 rtl/led_pattern_seq_if.sv | 22 ++
 rtl/led_pattern_seq.sv | 108 ++++++++++
 tb/tb_led_pattern_seq.sv | 130 +++++++++++++
 3 files changed

// File: rtl/led_pattern_seq_if.sv
// LED sequencer control/status bundle.
// Master drives run/mode/period, slave returns LED pattern and step strobe.
interface led_pattern_seq_if #(
  parameter int NLEDS     = 8,
  parameter int DIV_WIDTH = 25
);
  logic                 RUN;
  logic [1:0]           MODE;
  logic [DIV_WIDTH-1:0] PERIOD;
  logic [NLEDS-1:0]     LED;
  logic                 STEP;

  modport master (
    output RUN, MODE, PERIOD,
    input  LED, STEP
  );

  modport slave (
    input  RUN, MODE, PERIOD,
    output LED, STEP
  );
endinterface

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: rotate left/right, bounce, binary count.
// Programmable prescaler tick, run/pause, one-cycle step strobe.
module led_pattern_seq #(
  parameter int NLEDS     = 8,
  parameter int DIV_WIDTH = 25
) (
  input  logic               CLK,
  input  logic               RESETN,
  led_pattern_seq_if.slave   bus
);

  localparam logic [1:0] M_ROL = 2'b00;
  localparam logic [1:0] M_ROR = 2'b01;
  localparam logic [1:0] M_BNC = 2'b10;
  localparam logic [1:0] M_CNT = 2'b11;

  localparam logic [0:0] DIR_UP = 1'b0;
  localparam logic [0:0] DIR_DN = 1'b1;

  localparam logic [NLEDS-1:0] ONE = NLEDS'(1);
  localparam logic [NLEDS-1:0] TOP = ONE << (NLEDS - 1);

  logic [NLEDS-1:0]     led_q, led_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           mode_q, mode_d;
  logic [0:0]           dir_q, dir_d;
  logic                 step_q, step_d;

  logic                 reinit;
  logic                 tick;
  logic [NLEDS-1:0]     init_val;

  assign reinit = (bus.MODE != mode_q);
  assign tick   = bus.RUN && !reinit && (cnt_q >= bus.PERIOD);

  always_comb begin
    init_val = ONE;
    unique case (bus.MODE)
      M_ROL: init_val = ONE;
      M_ROR: init_val = TOP;
      M_BNC: init_val = ONE;
      M_CNT: init_val = '0;
      default: init_val = ONE;
    endcase
  end

  always_comb begin
    led_d  = led_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    mode_d = bus.MODE;
    if (reinit) begin
      led_d = init_val;
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (tick) begin
      cnt_d  = '0;
      step_d = 1'b1;
      unique case (mode_q)
        M_ROL: led_d = {led_q[NLEDS-2:0], led_q[NLEDS-1]};
        M_ROR: led_d = {led_q[0], led_q[NLEDS-1:1]};
        M_BNC: begin
          // end LEDs turn around immediately so each is lit one tick
          if (dir_q == DIR_UP) begin
            if (led_q[NLEDS-1]) begin
              dir_d = DIR_DN;
              led_d = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              dir_d = DIR_UP;
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        M_CNT: led_d = led_q + ONE;
        default: led_d = led_q;
      endcase
    end else if (bus.RUN) begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      led_q  <= ONE;
      cnt_q  <= '0;
      mode_q <= M_ROL;
      dir_q  <= DIR_UP;
      step_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

  assign bus.LED  = led_q;
  assign bus.STEP = step_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq (NLEDS=8, DIV_WIDTH=8).
// Stimulus pushes expected LED/STEP per edge; monitor pops at negedge.
module tb_led_pattern_seq;

  typedef struct {
    logic [7:0] led;
    logic       stp;
    int         id;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;
  exp_t sbq[$];

  led_pattern_seq_if #(.NLEDS(8), .DIV_WIDTH(8)) bus ();

  led_pattern_seq #(.NLEDS(8), .DIV_WIDTH(8)) dut (
    .CLK   (clk),
    .RESETN(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [7:0] led, input logic stp);
    exp_t e;
    @(posedge clk);
    e.led = led;
    e.stp = stp;
    e.id  = vec;
    vec++;
    sbq.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (bus.LED !== e.led || bus.STEP !== e.stp) begin
        errors++;
        $display("FAIL vec%0d: LED=%h STEP=%b expected LED=%h STEP=%b",
                 e.id, bus.LED, bus.STEP, e.led, e.stp);
      end
    end
  end

  initial begin
    logic [7:0] b [15];
    logic [7:0] p;
    b = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
          8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    // reset, rotate left with PERIOD=3
    rstn       = 1'b0;
    bus.RUN    = 1'b1;
    bus.MODE   = 2'b00;
    bus.PERIOD = 8'd3;
    step(8'h01, 1'b0);
    step(8'h01, 1'b0);
    rstn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      p = 8'h01 << ((k - 1) % 8);
      repeat (3) step(p, 1'b0);
      p = 8'h01 << (k % 8);
      step(p, 1'b1);
    end

    // bounce, PERIOD=0
    bus.MODE   = 2'b10;
    bus.PERIOD = 8'd0;
    step(8'h01, 1'b0);
    for (int i = 0; i < 15; i++) step(b[i], 1'b1);

    // mid-count switch to binary count
    bus.PERIOD = 8'd3;
    step(8'h02, 1'b0);
    step(8'h02, 1'b0);
    bus.MODE = 2'b11;
    step(8'h00, 1'b0);
    bus.PERIOD = 8'd0;
    for (int i = 1; i <= 256; i++) step(8'(i), 1'b1);

    // switch to rotate right
    bus.MODE = 2'b01;
    step(8'h80, 1'b0);
    step(8'h40, 1'b1);

    // pause mid-period
    bus.PERIOD = 8'd9;
    repeat (5) step(8'h40, 1'b0);
    bus.RUN = 1'b0;
    repeat (20) step(8'h40, 1'b0);
    bus.RUN = 1'b1;
    repeat (4) step(8'h40, 1'b0);
    step(8'h20, 1'b1);

    // PERIOD shrink below current count
    repeat (7) step(8'h20, 1'b0);
    bus.PERIOD = 8'd2;
    step(8'h10, 1'b1);
    repeat (2) step(8'h10, 1'b0);
    step(8'h08, 1'b1);
    repeat (2) step(8'h08, 1'b0);
    step(8'h04, 1'b1);

    // reset mid-operation, then reinit to rotate right
    rstn = 1'b0;
    step(8'h01, 1'b0);
    rstn = 1'b1;
    step(8'h80, 1'b0);
    repeat (2) step(8'h80, 1'b0);
    step(8'h40, 1'b1);

    // drain scoreboard with a bounded wait
    for (int t = 0; t < 5 && sbq.size() > 0; t++) @(posedge clk);
    @(posedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
